i2c_cmd_arbiter: RTL and testbench

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2c_arb_pkg.sv | 25 ++
 rtl/i2c_cmd_arbiter_rr.sv | 31 +++
 rtl/i2c_cmd_arbiter.sv | 119 +++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C command arbiter: FSM encoding, completion codes and command layout.
// Every field offset into a requester's command slice is defined here.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int CMD_W     = 24;
  localparam int RW_BIT    = 23;
  localparam int SADDR_LSB = 16;
  localparam int SADDR_W   = 7;
  localparam int RADDR_LSB = 8;
  localparam int RADDR_W   = 8;
  localparam int WDATA_LSB = 0;
  localparam int WDATA_W   = 8;

endpackage

// File: rtl/i2c_cmd_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 to 0.
// Zero latency; no state, so the caller owns the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master engine among NREQ requesters, one command in flight at a time.
// Grant->m_start is 1 cycle (held off while m_busy); m_done->rsp_valid is 1 cycle; WAIT_DONE is bounded by TIMEOUT.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [CMD_W*NREQ-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  m_start,
  output logic                  m_rw,
  output logic [6:0]            m_saddr,
  output logic [7:0]            m_raddr,
  output logic [7:0]            m_wdata,
  input  logic                  m_busy,
  input  logic                  m_done,
  input  logic [7:0]            m_rdata,
  input  logic                  m_nack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, owner_q, arb_idx;
  logic [NREQ-1:0]  arb_grant;
  logic             arb_any;
  logic [CMD_W-1:0] cmd_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       rdata_q;
  logic [1:0]       err_q;
  logic             timeout_hit;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arb_any) state_d = LAUNCH;
      LAUNCH:    if (!m_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (m_done || timeout_hit) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // req_ready is masked by rst so a pending request is not acknowledged while held in reset.
  always_comb begin
    req_ready = '0;
    m_start   = 1'b0;
    rsp_valid = '0;
    case (state_q)
      IDLE:    if (!rst) req_ready = arb_grant;
      LAUNCH:  m_start = !m_busy;
      RESP:    rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: if (arb_any) begin
          owner_q <= arb_idx;
          cmd_q   <= req_cmd[arb_idx*CMD_W +: CMD_W];
        end
        LAUNCH: cnt_q <= '0;
        WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion landing on the last allowed cycle still counts as a completion.
          if (m_done) begin
            rdata_q <= cmd_q[RW_BIT] ? m_rdata : 8'h00;
            err_q   <= m_nack ? ERR_NACK : ERR_OK;
          end else if (timeout_hit) begin
            rdata_q <= 8'h00;
            err_q   <= ERR_TIMEOUT;
          end
        end
        RESP: ptr_q <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_rw      = cmd_q[RW_BIT];
  assign m_saddr   = cmd_q[SADDR_LSB +: SADDR_W];
  assign m_raddr   = cmd_q[RADDR_LSB +: RADDR_W];
  assign m_wdata   = cmd_q[WDATA_LSB +: WDATA_W];

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench for i2c_cmd_arbiter against a transaction-level model of grant order, latencies and completion status.
module tb_i2c_cmd_arbiter;

  localparam int TO = 16;

  logic        clk, rst;
  logic [3:0]  req_valid;
  logic [95:0] req_cmd;
  logic [3:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        m_start, m_rw;
  logic [6:0]  m_saddr;
  logic [7:0]  m_raddr, m_wdata;
  logic        m_busy, m_done, m_nack;
  logic [7:0]  m_rdata;

  logic [23:0] cmds [4];
  int          model_ptr;
  int          n_tests, n_fail;
  int          g;
  int          rr_exp [5];

  i2c_cmd_arbiter #(.NREQ(4), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_start   (m_start),
    .m_rw      (m_rw),
    .m_saddr   (m_saddr),
    .m_raddr   (m_raddr),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rdata   (m_rdata),
    .m_nack    (m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmds();
    for (int i = 0; i < 4; i++) req_cmd[i*24 +: 24] = cmds[i];
  endtask

  task automatic scramble();
    req_valid = 4'($urandom);
    req_cmd   = {$urandom, $urandom, $urandom};
  endtask

  task automatic chk_fields(input logic [23:0] ec);
    chk("m_rw",    32'(m_rw),    32'(ec[23]));
    chk("m_saddr", 32'(m_saddr), 32'(ec[22:16]));
    chk("m_raddr", 32'(m_raddr), 32'(ec[15:8]));
    chk("m_wdata", 32'(m_wdata), 32'(ec[7:0]));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   0);
    chk({tag, "_m_start"},   32'(m_start),   0);
    chk({tag, "_fields"},    32'({m_rw, m_saddr, m_raddr, m_wdata}), 0);
  endtask

  // Called at the drive point of an IDLE cycle. d = WAIT_DONE cycle index of m_done (-1: never).
  task automatic do_txn(input logic [3:0] vld, input int busy, input int d, input bit nack,
                        input logic [7:0] rdat, output int gidx);
    int w, resp_i;
    logic [1:0]  exp_err;
    logic [7:0]  exp_rd;
    logic [23:0] ec;
    req_valid = vld;
    drive_cmds();
    m_busy = 1'b0;
    m_done = 1'b0;
    w  = model_pick(vld, model_ptr);
    ec = cmds[w];
    #2;
    chk("req_ready", 32'(req_ready), oh(w));
    chk("m_start_idle", 32'(m_start), 0);
    gidx = oh_idx(req_ready);
    // Launch phase: m_busy holds off m_start; stray m_done here must be ignored.
    for (int k = 0; k <= busy; k++) begin
      cyc();
      scramble();
      m_busy = (k < busy);
      m_done = (k < busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_nack = 1'($urandom_range(0, 1));
      #2;
      chk("m_start", 32'(m_start), 32'(k == busy));
      chk("req_ready_busy", 32'(req_ready), 0);
      chk_fields(ec);
    end
    if (d >= 0 && d < TO) begin
      resp_i  = d + 1;
      exp_err = nack ? 2'b01 : 2'b00;
      exp_rd  = ec[23] ? rdat : 8'h00;
    end else begin
      resp_i  = TO;
      exp_err = 2'b10;
      exp_rd  = 8'h00;
    end
    for (int i = 0; i <= resp_i; i++) begin
      cyc();
      scramble();
      m_busy  = (i < resp_i);
      m_done  = (i == d);
      m_nack  = (i == d) ? nack : 1'($urandom_range(0, 1));
      m_rdata = (i == d) ? rdat : 8'($urandom);
      if (i == resp_i) req_valid = 4'b0000;
      #2;
      chk("m_start_wait", 32'(m_start), 0);
      chk("req_ready_wait", 32'(req_ready), 0);
      if (i == resp_i) begin
        chk("rsp_valid", 32'(rsp_valid), oh(w));
        chk("rsp_err",   32'(rsp_err),   32'(exp_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      end else begin
        chk("rsp_early", 32'(rsp_valid), 0);
      end
      chk_fields(ec);
    end
    model_ptr = (w + 1) % 4;
    cyc();
    req_valid = 4'b0000;
    m_busy    = 1'b0;
    m_done    = 1'($urandom_range(0, 1));
    #2;
    chk("rsp_pulse_width", 32'(rsp_valid), 0);
    chk("req_ready_after", 32'(req_ready), 0);
    cyc();
    m_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    model_ptr = 0;
    rr_exp    = '{0, 1, 2, 3, 0};
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_cmd   = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_nack    = 1'b0;
    m_rdata   = 8'h00;
    for (int i = 0; i < 4; i++) cmds[i] = 24'($urandom);
    #12;
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Round robin with all requesters pending.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) cmds[i] = 24'($urandom);
      do_txn(4'b1111, 0, 2 + t, 1'b0, 8'h11, g);
      chk("rr_order", 32'(g), 32'(rr_exp[t]));
    end

    // Single write; m_done lands 10 cycles after req_ready.
    cmds[0] = {1'b0, 7'h50, 8'h10, 8'hA5};
    do_txn(4'b0001, 0, 8, 1'b0, 8'hC3, g);
    chk("write_owner", 32'(g), 0);

    // Read NACKed by the target.
    cmds[2] = {1'b1, 7'h3C, 8'h02, 8'($urandom)};
    do_txn(4'b0100, 0, 3, 1'b1, 8'h7E, g);
    chk("nack_owner", 32'(g), 2);

    // Reset in the middle of WAIT_DONE.
    cmds[1] = {1'b1, 7'h2A, 8'h44, 8'h99};
    req_valid = 4'b0010;
    drive_cmds();
    #2;
    chk("rstmid_grant", 32'(req_ready), 32'(4'b0010));
    cyc();
    req_valid = 4'b0000;
    #2;
    chk("rstmid_start", 32'(m_start), 1);
    cyc();
    cyc();
    cyc();
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk_outputs_zero("rstmid");
    cyc();
    cyc();
    rst       = 1'b0;
    req_valid = 4'b0000;
    m_done    = 1'b1;
    m_rdata   = 8'hEE;
    #2;
    chk("late_done_0", 32'(rsp_valid), 0);
    cyc();
    m_done = 1'b0;
    #2;
    chk("late_done_1", 32'(rsp_valid), 0);
    cyc();
    model_ptr = 0;
    do_txn(4'b1111, 0, 1, 1'b0, 8'h00, g);
    chk("post_reset_first", 32'(g), 0);

    // Timeout, then m_done coincident with the last allowed cycle.
    cmds[1] = {1'b1, 7'h11, 8'h22, 8'h33};
    do_txn(4'b0010, 0, -1, 1'b0, 8'h00, g);
    cmds[3] = {1'b1, 7'h12, 8'h34, 8'h56};
    do_txn(4'b1000, 0, TO - 1, 1'b0, 8'h5A, g);

    // Engine busy for 5 cycles after the grant.
    do_txn(4'b0001, 5, 4, 1'b0, 8'h00, g);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) cmds[i] = 24'($urandom);
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 21)) - 1, 1'($urandom_range(0, 1)), 8'($urandom), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
